// File: rtl/acc_job_scheduler_if.sv
// Job request handshake plus accelerator start/done/idle and output-stream snoop.
interface acc_job_scheduler_if;
  logic       job_valid;
  logic [1:0] job_type;
  logic       job_ready;
  logic [2:0] ap_start;
  logic       ap_idle;
  logic [2:0] ap_done;
  logic       sm_tvalid;
  logic       sm_tready;
  logic       sm_tlast;

  modport master (
    output job_valid, job_type, ap_idle, ap_done, sm_tvalid, sm_tready, sm_tlast,
    input  job_ready, ap_start
  );

  modport slave (
    input  job_valid, job_type, ap_idle, ap_done, sm_tvalid, sm_tready, sm_tlast,
    output job_ready, ap_start
  );
endinterface

// File: rtl/acc_job_scheduler.sv
// Queues kernel jobs and runs them one at a time on the accelerator, checking
// done/beat consistency and guarding each job with a watchdog.
module acc_job_scheduler #(
  parameter int QDEPTH  = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  acc_job_scheduler_if.slave      bus,
  input  logic                    err_clr,
  output logic                    busy,
  output logic [1:0]              cur_job,
  output logic [$clog2(QDEPTH):0] q_count,
  output logic [7:0]              jobs_done,
  output logic [2:0]              err
);
  localparam int PW  = $clog2(QDEPTH);
  localparam int CW  = PW + 1;
  localparam int WDW = ($clog2(TIMEOUT + 1) > 12) ? $clog2(TIMEOUT + 1) : 12;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, RUN, DRAIN, WAITIDLE, HALT} state_t;
  state_t state_reg, state_next;

  logic [1:0]     mem [QDEPTH];
  logic [PW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]  count_reg;
  logic [1:0]     cur_job_reg;
  logic [2:0]     ap_start_reg;
  logic [6:0]     beat_reg, beat_inc;
  logic [WDW-1:0] wd_reg;
  logic           job_err_reg;
  logic [7:0]     jobs_done_reg;
  logic [2:0]     err_reg, err_set;
  logic           accept, push, pop, beat, wd_hit;
  logic           timeout, done_bad, last_ok, last_bad;

  function automatic logic [2:0] onehot(input logic [1:0] t);
    case (t)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [6:0] beats_expected(input logic [1:0] t);
    case (t)
      2'd0:    return 7'd64;
      2'd1:    return 7'd16;
      2'd2:    return 7'd10;
      default: return 7'd0;
    endcase
  endfunction

  assign bus.job_ready = (count_reg != CW'(QDEPTH));
  assign accept   = bus.job_valid & bus.job_ready;
  // Illegal type 3 still completes the handshake but never enters the queue.
  assign push     = accept & (bus.job_type != 2'd3);
  assign beat     = bus.sm_tvalid & bus.sm_tready;
  assign beat_inc = (beat_reg == 7'd127) ? beat_reg : beat_reg + 7'd1;
  assign wd_hit   = (wd_reg == WD_LAST);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    timeout    = 1'b0;
    done_bad   = 1'b0;
    last_ok    = 1'b0;
    last_bad   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (count_reg != '0 && bus.ap_idle) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = RUN;
      RUN: begin
        if (wd_hit) begin
          timeout    = 1'b1;
          state_next = HALT;
        end else if (bus.ap_done != 3'b000) begin
          done_bad   = (bus.ap_done != onehot(cur_job_reg));
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (wd_hit) begin
          timeout    = 1'b1;
          state_next = HALT;
        end else if (beat && bus.sm_tlast) begin
          last_ok    = (beat_inc == beats_expected(cur_job_reg));
          last_bad   = ~last_ok;
          state_next = WAITIDLE;
        end
      end
      WAITIDLE: if (bus.ap_idle) state_next = IDLE;
      HALT:     if (err_clr) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  assign err_set = {timeout, done_bad | last_bad, accept & (bus.job_type == 2'd3)};

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= bus.job_type;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      cur_job_reg   <= 2'd0;
      ap_start_reg  <= 3'b000;
      beat_reg      <= 7'd0;
      wd_reg        <= '0;
      job_err_reg   <= 1'b0;
      jobs_done_reg <= 8'd0;
      err_reg       <= 3'b000;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop) begin
        rd_ptr_reg  <= rd_ptr_reg + 1'b1;
        cur_job_reg <= mem[rd_ptr_reg];
      end
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
      // The start pulse is launched with the pop so it is high exactly during ISSUE.
      ap_start_reg <= pop ? onehot(mem[rd_ptr_reg]) : 3'b000;
      if (state_reg == ISSUE) begin
        beat_reg    <= 7'd0;
        wd_reg      <= '0;
        job_err_reg <= 1'b0;
      end else begin
        if (state_reg == DRAIN && beat) beat_reg <= beat_inc;
        if (state_reg == RUN || state_reg == DRAIN) wd_reg <= wd_reg + 1'b1;
        if (done_bad) job_err_reg <= 1'b1;
      end
      if (last_ok && !job_err_reg) jobs_done_reg <= jobs_done_reg + 8'd1;
      // A fresh error event outranks a simultaneous clear.
      err_reg <= err_set | (err_reg & {3{~err_clr}});
    end
  end

  assign bus.ap_start = ap_start_reg;
  assign busy         = (state_reg != IDLE);
  assign cur_job      = cur_job_reg;
  assign q_count      = count_reg;
  assign jobs_done    = jobs_done_reg;
  assign err          = err_reg;
endmodule

// File: tb/tb_acc_job_scheduler.sv
// Scoreboarded bench: a long-timeout instance for normal traffic and a
// TIMEOUT=32 instance for the watchdog; only the selected one is out of reset.
module tb_acc_job_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, sel_to, err_clr, job_valid, ap_idle, tvalid, tready, tlast;
  logic [1:0] job_type;
  logic [2:0] ap_done;
  logic       rst_a, rst_b;
  logic       busy_a, busy_b;
  logic [1:0] cur_a, cur_b;
  logic [2:0] qc_a, qc_b;
  logic [7:0] jd_a, jd_b;
  logic [2:0] err_a, err_b;

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  logic [2:0] exp_q[$];
  logic [2:0] exp_start;
  logic [2:0] prev_start = 3'b000;

  acc_job_scheduler_if bus_a();
  acc_job_scheduler_if bus_b();

  assign bus_a.job_valid = job_valid;  assign bus_b.job_valid = job_valid;
  assign bus_a.job_type  = job_type;   assign bus_b.job_type  = job_type;
  assign bus_a.ap_idle   = ap_idle;    assign bus_b.ap_idle   = ap_idle;
  assign bus_a.ap_done   = ap_done;    assign bus_b.ap_done   = ap_done;
  assign bus_a.sm_tvalid = tvalid;     assign bus_b.sm_tvalid = tvalid;
  assign bus_a.sm_tready = tready;     assign bus_b.sm_tready = tready;
  assign bus_a.sm_tlast  = tlast;      assign bus_b.sm_tlast  = tlast;
  assign rst_a = rst | sel_to;
  assign rst_b = rst | ~sel_to;

  acc_job_scheduler #(.QDEPTH(4), .TIMEOUT(4096)) dut (
    .clk(clk), .rst(rst_a), .bus(bus_a), .err_clr(err_clr), .busy(busy_a),
    .cur_job(cur_a), .q_count(qc_a), .jobs_done(jd_a), .err(err_a)
  );

  acc_job_scheduler #(.QDEPTH(4), .TIMEOUT(32)) dut_to (
    .clk(clk), .rst(rst_b), .bus(bus_b), .err_clr(err_clr), .busy(busy_b),
    .cur_job(cur_b), .q_count(qc_b), .jobs_done(jd_b), .err(err_b)
  );

  logic [2:0] ap_start_s, q_count_s, err_s;
  logic [1:0] cur_job_s;
  logic [7:0] jobs_done_s;
  logic       busy_s, job_ready_s;
  assign ap_start_s  = sel_to ? bus_b.ap_start  : bus_a.ap_start;
  assign job_ready_s = sel_to ? bus_b.job_ready : bus_a.job_ready;
  assign busy_s      = sel_to ? busy_b : busy_a;
  assign cur_job_s   = sel_to ? cur_b  : cur_a;
  assign q_count_s   = sel_to ? qc_b   : qc_a;
  assign jobs_done_s = sel_to ? jd_b   : jd_a;
  assign err_s       = sel_to ? err_b  : err_a;

  function automatic logic [2:0] tb_onehot(input int t);
    case (t)
      0:       return 3'b001;
      1:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic int tb_beats(input int t);
    case (t)
      0:       return 64;
      1:       return 16;
      default: return 10;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Every start pulse must match the next expected job and last one cycle only.
  always @(negedge clk) begin
    if (ap_start_s != 3'b000) begin
      start_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL start_unexpected actual=%b required=none", ap_start_s);
      end else begin
        exp_start = exp_q.pop_front();
        if (exp_start != ap_start_s || prev_start != 3'b000) begin
          failures++;
          $display("FAIL start_order actual=%b prev=%b required=%b", ap_start_s, prev_start, exp_start);
        end else begin
          $display("start ok ap_start=%b", ap_start_s);
        end
      end
    end
    prev_start = ap_start_s;
  end

  task automatic push(input logic [1:0] t, input logic expect_start);
    job_valid = 1'b1;
    job_type  = t;
    @(posedge clk); #1;
    job_valid = 1'b0;
    if (expect_start) exp_q.push_back(tb_onehot(int'(t)));
  endtask

  task automatic wait_start();
    int n = 0;
    while (ap_start_s == 3'b000 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (ap_start_s == 3'b000) begin
      checks++;
      failures++;
      $display("FAIL start_wait actual=none required=start within 100 cycles");
    end
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  // Called in the ISSUE cycle; returns once the scheduler is back in IDLE.
  task automatic run_job(input logic [2:0] done_val, input int nbeats);
    ap_idle = 1'b0;
    @(posedge clk); #1;
    tvalid = 1'b1; tready = 1'b1;
    @(posedge clk); #1;
    tvalid = 1'b0; tready = 1'b0;
    ap_done = done_val;
    @(posedge clk); #1;
    ap_done = 3'b000;
    tvalid = 1'b1; tready = 1'b0; tlast = 1'b1;
    @(posedge clk); #1;
    tready = 1'b1;
    for (int i = 1; i <= nbeats; i++) begin
      tlast = (i == nbeats);
      @(posedge clk); #1;
    end
    tvalid = 1'b0; tready = 1'b0; tlast = 1'b0;
    @(posedge clk); #1;
    ap_idle = 1'b1;
    @(posedge clk); #1;
    $display("job done_val=%b beats=%0d jobs_done=%0d err=%b", done_val, nbeats, jobs_done_s, err_s);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ap_start"}, ap_start_s, 0);
    chk({tag, "_busy"}, busy_s, 0);
    chk({tag, "_cur_job"}, cur_job_s, 0);
    chk({tag, "_q_count"}, q_count_s, 0);
    chk({tag, "_jobs_done"}, jobs_done_s, 0);
    chk({tag, "_err"}, err_s, 0);
    chk({tag, "_job_ready"}, job_ready_s, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int fill_types[4] = '{0, 1, 2, 0};
    int sc;
    rst = 1'b1; sel_to = 1'b0; err_clr = 1'b0; job_valid = 1'b0; job_type = 2'd0;
    ap_idle = 1'b1; ap_done = 3'b000; tvalid = 1'b0; tready = 1'b0; tlast = 1'b0;
    repeat (3) @(posedge clk); #1;
    reset_checks("reset");
    rst = 1'b0;

    // Single FIR job with exact dispatch latency.
    push(2'd0, 1'b1);
    chk("fir_q_count", q_count_s, 1);
    chk("fir_start_early", ap_start_s, 0);
    @(posedge clk); #1;
    chk("fir_start_latency", ap_start_s, 1);
    chk("fir_busy", busy_s, 1);
    run_job(3'b001, 64);
    chk("fir_jobs_done", jobs_done_s, 1);
    chk("fir_err", err_s, 0);
    chk("fir_busy_low", busy_s, 0);

    // Queue fill while the accelerator reports busy.
    ap_idle = 1'b0;
    for (int k = 0; k < 4; k++) push(2'(fill_types[k]), 1'b1);
    chk("fill_ready_full", job_ready_s, 0);
    chk("fill_q_count", q_count_s, 4);
    push(2'd1, 1'b0);
    chk("fill_q_count_after5", q_count_s, 4);
    ap_idle = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_start();
      chk("fill_cur_job", cur_job_s, fill_types[k]);
      run_job(tb_onehot(fill_types[k]), tb_beats(fill_types[k]));
    end
    chk("fill_jobs_done", jobs_done_s, 5);
    chk("fill_err", err_s, 0);

    // Illegal type, then matmul job answered with the sorting done bit.
    push(2'd3, 1'b0);
    chk("illegal_err", err_s, 1);
    chk("illegal_q_count", q_count_s, 0);
    push(2'd1, 1'b1);
    wait_start();
    run_job(3'b100, 16);
    chk("wrongdone_err", err_s, 3);
    chk("wrongdone_jobs_done", jobs_done_s, 5);
    clear_err();
    chk("errclr_err", err_s, 0);

    // Sorting job with tlast one beat early.
    push(2'd2, 1'b1);
    wait_start();
    run_job(3'b100, 9);
    chk("beat_err", err_s, 2);
    chk("beat_jobs_done", jobs_done_s, 5);
    chk("beat_busy", busy_s, 0);
    clear_err();

    // Watchdog on the TIMEOUT=32 instance.
    sel_to = 1'b1;
    @(posedge clk); #1;
    chk("to_fresh_jobs_done", jobs_done_s, 0);
    push(2'd0, 1'b1);
    wait_start();
    ap_idle = 1'b0;
    repeat (30) @(posedge clk); #1;
    chk("to_err_before", err_s, 0);
    chk("to_busy_run", busy_s, 1);
    repeat (4) @(posedge clk); #1;
    chk("to_err_after", err_s, 4);
    ap_idle = 1'b1;
    push(2'd1, 1'b1);
    push(2'd2, 1'b1);
    sc = start_cnt;
    repeat (10) @(posedge clk); #1;
    chk("halt_no_dispatch", start_cnt, sc);
    chk("halt_q_count", q_count_s, 2);
    chk("halt_busy", busy_s, 1);
    clear_err();
    chk("halt_errclr", err_s, 0);
    wait_start();
    chk("resume_cur_job", cur_job_s, 1);
    run_job(3'b010, 16);
    wait_start();
    run_job(3'b100, 10);
    chk("resume_jobs_done", jobs_done_s, 2);
    chk("resume_err", err_s, 0);

    // Reset in DRAIN with two jobs waiting.
    sel_to = 1'b0;
    @(posedge clk); #1;
    push(2'd0, 1'b1);
    wait_start();
    ap_idle = 1'b0;
    push(2'd1, 1'b0);
    push(2'd2, 1'b0);
    ap_done = 3'b001;
    @(posedge clk); #1;
    ap_done = 3'b000;
    tvalid = 1'b1; tready = 1'b1;
    repeat (5) @(posedge clk); #1;
    chk("drain_q_count", q_count_s, 2);
    rst = 1'b1; tvalid = 1'b0; tready = 1'b0;
    @(posedge clk); #1;
    reset_checks("midrst");
    rst = 1'b0;
    ap_idle = 1'b1;
    sc = start_cnt;
    repeat (20) @(posedge clk); #1;
    chk("midrst_no_start", start_cnt, sc);
    chk("midrst_busy", busy_s, 0);
    chk("pending_starts", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
